burst_master: RTL and testbench

Parametrised bus master that accepts commands over a valid/ready port, waits for an arbiter grant, and drives a req/ack handshake to a single slave. Writes are single-beat. Reads are bursts of 1..MAX_BURST beats at incrementing addresses, and the returned data is pushed into an internal read FIFO. The block sits between command logic and the shared slave bus arbiter, and supersedes the fixed 32-bit, 8-entry single-beat master.

---
 rtl/pkg_bm.sv | 26 ++
 rtl/bm_fifo.sv | 54 +++++
 rtl/burst_master.sv | 166 ++++++++++++++++
 tb/tb_burst_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_bm.sv
// Shared types and default sizing for the burst master.
// Latency: none (types only).
// Backpressure: none (types only).
package pkg_bm;

  localparam int BM_AW        = 16;
  localparam int BM_DW        = 32;
  localparam int BM_MAX_BURST = 8;
  localparam int BM_LW        = $clog2(BM_MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    REQ  = 2'd2,
    GAP  = 2'd3
  } t_bm_st;

  // One command as seen on the cmd_* port, sized at the default parameters.
  typedef struct packed {
    logic             wr;
    logic [BM_AW-1:0] addr;
    logic [BM_DW-1:0] data;
    logic [BM_LW-1:0] len;
  } t_bm_cmd;

endpackage

// File: rtl/bm_fifo.sv
// Circular read-data buffer, DEPTH x DW, power-of-two depth.
// Latency: a push is visible on pop_data/count one cycle later; pop_data is the combinational head.
// Backpressure: none internally; push while full and pop while empty are dropped.
// Ports: push/push_data write side, pop/pop_data read side, count/empty/full status.
module bm_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  // Storage is not reset: the pointers alone define which words are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/burst_master.sv
// Bus master: takes a command, waits for grant, runs single-beat writes or 1..MAX_BURST-beat reads into a FIFO.
// Latency: done pulses 2*beats+1 cycles after the command handshake with immediate grant and ack.
// Backpressure: cmd_ready low while busy; reads wait in ARB until the FIFO can take the whole burst.
// Ports: cmd_* command in, gnt arbiter grant, bus_* req/ack slave side, pop/pop_data/count/empty/full
//        read FIFO, busy/done/err status. Optional ack timeout: define BURST_MASTER_TIMEOUT_EN.
module burst_master
  import pkg_bm::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_BURST   = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_wr,
  input  logic [AW-1:0]                cmd_addr,
  input  logic [DW-1:0]                cmd_data,
  input  logic [$clog2(MAX_BURST)-1:0] cmd_len,
  input  logic                         gnt,
  output logic                         bus_req,
  output logic                         bus_cmd,
  output logic [AW-1:0]                bus_addr,
  output logic [DW-1:0]                bus_data,
  input  logic                         bus_ack,
  input  logic [DW-1:0]                bus_rdata,
  input  logic                         pop,
  output logic [DW-1:0]                pop_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int LW = $clog2(MAX_BURST);
  localparam int BW = LW + 1;              // holds MAX_BURST itself
  localparam int CW = $clog2(DEPTH) + 1;

  // Parameter sanity: power-of-two depth >= 2, bursts fit the FIFO, non-zero timeout.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_BURST < 2 || MAX_BURST > DEPTH ||
      TIMEOUT_CYC < 1) begin : g_bad_param
    $error("burst_master: illegal parameter combination");
  end

  t_bm_st        st;
  logic [BW-1:0] beats;
  logic          fifo_push;
  logic          rd_space_ok;

  // Only REQ consumes bus_ack; acks in any other state are ignored.
  assign fifo_push   = (st == REQ) && bus_ack && !bus_cmd;
  // Space is judged on the registered count only; a pop in this cycle is not credited.
  assign rd_space_ok = (CW'(DEPTH) - count) >= CW'(beats);

`ifdef BURST_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      cmd_ready <= 1'b1;
      bus_req   <= 1'b0;
      bus_cmd   <= 1'b0;
      bus_addr  <= '0;
      bus_data  <= '0;
      beats     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef BURST_MASTER_TIMEOUT_EN
      to_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef BURST_MASTER_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (st)
        IDLE: begin
          if (cmd_valid) begin
            bus_cmd   <= cmd_wr;
            bus_addr  <= cmd_addr;
            bus_data  <= cmd_data;
            beats     <= cmd_wr ? BW'(1) : BW'(cmd_len) + BW'(1);
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            st        <= ARB;
          end
        end
        ARB: begin
          if (gnt && (bus_cmd || rd_space_ok)) begin
            bus_req <= 1'b1;
            st      <= REQ;
`ifdef BURST_MASTER_TIMEOUT_EN
            to_cnt  <= '0;
`endif
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            beats   <= beats - BW'(1);
            st      <= GAP;
          end
`ifdef BURST_MASTER_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            // Abandon the rest of the burst; words already pushed stay queued.
            bus_req   <= 1'b0;
            done      <= 1'b1;
            err_q     <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            st        <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
        GAP: begin
          // Grant is held for the whole burst; no return to ARB between beats.
          if (beats != '0) begin
            bus_addr <= bus_addr + AW'(1);
            bus_req  <= 1'b1;
            st       <= REQ;
`ifdef BURST_MASTER_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end else begin
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  bm_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (bus_rdata),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

endmodule

// File: tb/tb_burst_master.sv
// Randomised and directed bench for burst_master with a queue-based scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_burst_master;
  import pkg_bm::*;

  localparam int AW = 16, DW = 32, DEPTH = 16, MAX_BURST = 8, TIMEOUT_CYC = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [2:0]    cmd_len = '0;
  logic          gnt = 1'b0, bus_req, bus_cmd, bus_ack = 1'b0;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data, bus_rdata = '0, pop_data;
  logic          pop = 1'b0, empty, full, busy, done, err;
  logic [4:0]    count;

  burst_master #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len), .gnt(gnt), .bus_req(bus_req),
    .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_data(bus_data), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .pop(pop), .pop_data(pop_data), .count(count), .empty(empty),
    .full(full), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [15:0] addr; logic [31:0] data; bit first; } beat_t;

  beat_t       exp_bus[$];
  logic [31:0] exp_rd[$];
  int vec_cnt = 0, err_cnt = 0, cyc = 0, t0 = 0;
  int mcount = 0, low_cnt = 0, dly = 0, pop_mode = 0, pop_credit = 0, ack_dly_max = 0;
  bit gnt_rand = 0, spur_en = 0, slave_mute = 0, pop_on_ack = 0;
  bit in_beat = 0, acked = 0, prev_push = 0, prev_pop = 0, prev_done = 0;
  beat_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void fail(input string nm);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s at %0t", nm, $time);
  endfunction

  // Slave, FIFO occupancy model, bus monitor and pop checker, all sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mcount = 0; exp_bus.delete(); exp_rd.delete();
      prev_push = 0; prev_pop = 0; prev_done = 0; in_beat = 0; acked = 0; low_cnt = 0;
      bus_ack = 0; pop = 0;
    end else begin
      // Occupancy after the last edge: pop only took effect if something was stored.
      mcount = mcount + (prev_push ? 1 : 0) - ((prev_pop && mcount > 0) ? 1 : 0);
      check("count", 64'(count), 64'(mcount));
      check("empty", 64'(empty), 64'(mcount == 0));
      check("full", 64'(full), 64'(mcount == DEPTH));
      if (done) check("done_one_cycle", 64'(prev_done), 64'(0));
      prev_done = done;

      if (bus_req && !in_beat) begin
        in_beat = 1; acked = 0;
        dly = (ack_dly_max == 0) ? 0 : int'($urandom_range(ack_dly_max, 0));
        if (exp_bus.size() == 0) fail("unexpected_req");
        else begin
          cur = exp_bus.pop_front();
          check("bus_cmd", 64'(bus_cmd), 64'(cur.wr));
          check("bus_addr", 64'(bus_addr), 64'(cur.addr));
          check("bus_data", 64'(bus_data), 64'(cur.data));
          if (!cur.first) check("gap_cycles", 64'(low_cnt), 64'(1));
        end
      end else if (bus_req) begin
        check("req_hold", 64'({bus_cmd, bus_addr, bus_data}), 64'({cur.wr, cur.addr, cur.data}));
      end else begin
        low_cnt = in_beat ? 1 : low_cnt + 1;
        in_beat = 0;
      end

      bus_ack = 0; prev_push = 0; bus_rdata = $urandom;
      if (bus_req && !acked && !slave_mute) begin
        if (dly == 0) begin
          bus_ack = 1; acked = 1; prev_push = !bus_cmd;
          bus_rdata = {16'h0, 16'(bus_addr + 16'h0100)};
        end else dly--;
      end else if (!bus_req && spur_en && $urandom_range(3, 0) == 0) begin
        bus_ack = 1;
      end

      pop = 0;
      if (pop_mode == 1) pop = ($urandom_range(1, 0) == 1);
      else if (pop_mode == 2) pop = 1;
      else if (pop_credit > 0 && mcount > 0) begin pop = 1; pop_credit--; end
      if (pop_on_ack && prev_push) pop = 1;
      if (pop && mcount > 0) begin
        if (exp_rd.size() == 0) fail("pop_without_expected_word");
        else check("pop_data", 64'(pop_data), 64'(exp_rd.pop_front()));
      end
      prev_pop = pop;
      if (gnt_rand) gnt = ($urandom_range(2, 0) != 0);
    end
  end

  // Queue the expected beats and read words, then perform the handshake.
  task automatic send_cmd(input bit wr, input logic [15:0] a, input logic [31:0] d, input logic [2:0] len);
    t_bm_cmd c;
    beat_t   b;
    int      n, k;
    c = '{wr: wr, addr: a, data: d, len: len};
    n = c.wr ? 1 : int'(c.len) + 1;
    k = 0;
    while (!cmd_ready && k < 3000) begin @(negedge clk); k++; end
    if (!cmd_ready) fail("cmd_ready_timeout");
    for (int i = 0; i < n; i++) begin
      b.wr = c.wr; b.addr = c.addr + 16'(i); b.data = c.data; b.first = (i == 0);
      exp_bus.push_back(b);
      if (!c.wr) exp_rd.push_back({16'h0, 16'(b.addr + 16'h0100)});
    end
    cmd_valid = 1; cmd_wr = c.wr; cmd_addr = c.addr; cmd_data = c.data; cmd_len = c.len;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0; cmd_wr = $urandom_range(1, 0) == 1; cmd_addr = $urandom; cmd_data = $urandom;
    t0 = cyc;
    check("busy_after_cmd", 64'(busy), 64'(1));
    check("cmd_ready_after_cmd", 64'(cmd_ready), 64'(0));
  endtask

  task automatic wait_done(input bit exp_err, output int lat);
    lat = -1;
    for (int k = 0; k < 3000 && lat < 0; k++) begin
      @(negedge clk);
      if (done) lat = cyc - t0;
    end
    if (lat < 0) fail("done_timeout");
    else begin
      check("err_with_done", 64'(err), 64'(exp_err));
      check("beats_consumed", 64'(exp_bus.size()), 64'(0));
    end
  endtask

  task automatic drain();
    pop_mode = 0; pop_credit = 64;
    for (int k = 0; k < 500 && mcount != 0; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    pop_credit = 0;
    check("drained", 64'(count), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, hi;
    bit seen;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_bus_req", 64'(bus_req), 64'(0));
    check("rst_bus_cmd", 64'(bus_cmd), 64'(0));
    check("rst_bus_addr", 64'(bus_addr), 64'(0));
    check("rst_bus_data", 64'(bus_data), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done_err", 64'({done, err}), 64'(0));
    #2 rst_n = 1;
    @(negedge clk);

    // Single write with immediate grant and ack.
    gnt = 1;
    send_cmd(1, 16'h0010, 32'hDEADBEEF, 3'd0);
    wait_done(0, lat);
    check("write_latency", 64'(lat), 64'(3));
    check("write_fifo_empty", 64'(count), 64'(0));

    // Four-beat read across the address wrap.
    send_cmd(0, 16'hFFFE, 32'h0BADF00D, 3'd3);
    wait_done(0, lat);
    check("burst4_latency", 64'(lat), 64'(9));
    check("burst4_count", 64'(count), 64'(4));
    drain();

    // Grant withheld.
    gnt = 0;
    send_cmd(1, 16'h1234, 32'h5555AAAA, 3'd0);
    repeat (5) begin
      @(negedge clk);
      check("nognt_req_low", 64'(bus_req), 64'(0));
      check("nognt_busy", 64'(busy), 64'(1));
    end
    gnt = 1;
    wait_done(0, lat);

    // FIFO space stall: 14 words held, 4-beat read needs two pops first.
    send_cmd(0, 16'h0100, 32'h0, 3'd7); wait_done(0, lat);
    send_cmd(0, 16'h0200, 32'h0, 3'd5); wait_done(0, lat);
    check("prefill14", 64'(count), 64'(14));
    send_cmd(0, 16'h0300, 32'h0, 3'd3);
    repeat (6) begin
      @(negedge clk);
      check("space_stall_req", 64'(bus_req), 64'(0));
      check("space_stall_busy", 64'(busy), 64'(1));
    end
    #1 pop_credit = 1;
    repeat (4) begin @(negedge clk); check("space_stall_one_pop", 64'(bus_req), 64'(0)); end
    check("after_one_pop", 64'(count), 64'(13));
    #1 pop_credit = 1;
    @(negedge clk);
    @(negedge clk); check("space_pop_not_credited", 64'(bus_req), 64'(0));
    @(negedge clk); check("space_released", 64'(bus_req), 64'(1));
    wait_done(0, lat);
    check("space_full_after", 64'(full), 64'(1));
    drain();

    // Push and pop on the same edge at 15 entries.
    send_cmd(0, 16'h0400, 32'h0, 3'd7); wait_done(0, lat);
    send_cmd(0, 16'h0500, 32'h0, 3'd6); wait_done(0, lat);
    pop_on_ack = 1;
    send_cmd(0, 16'h0600, 32'h0, 3'd0); wait_done(0, lat);
    pop_on_ack = 0;
    check("push_pop_same_edge", 64'(count), 64'(15));
    drain();

    // Pop while empty.
    pop_mode = 2;
    repeat (4) @(negedge clk);
    pop_mode = 0;
    repeat (2) @(negedge clk);
    check("pop_empty_count", 64'(count), 64'(0));
    check("pop_empty_flag", 64'(empty), 64'(1));

    // Random commands, random grant, ack delay, spurious acks and pops.
    gnt_rand = 1; spur_en = 1; ack_dly_max = 3; pop_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send_cmd($urandom_range(1, 0) == 1, 16'($urandom), $urandom, 3'($urandom_range(7, 0)));
      wait_done(0, lat);
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    gnt_rand = 0; spur_en = 0; ack_dly_max = 0; gnt = 1;
    drain();

    // Ack never arrives.
    slave_mute = 1;
    send_cmd(1, 16'h0200, 32'h12345678, 3'd0);
    hi = 0; seen = 0;
`ifdef BURST_MASTER_TIMEOUT_EN
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        check("timeout_err", 64'(err), 64'(1));
        check("timeout_req_low", 64'(bus_req), 64'(0));
      end else if (bus_req) hi++;
    end
    if (!seen) fail("timeout_done_missing");
    check("timeout_req_cycles", 64'(hi), 64'(TIMEOUT_CYC));
    slave_mute = 0;
    @(negedge clk);
`else
    repeat (1000) @(negedge clk);
    check("no_timeout_req_high", 64'(bus_req), 64'(1));
    check("no_timeout_busy", 64'(busy), 64'(1));
    #2 rst_n = 0;
    #1 check("recover_req_low", 64'(bus_req), 64'(0));
    repeat (2) @(negedge clk);
    slave_mute = 0;
    #2 rst_n = 1;
    @(negedge clk);
`endif

    // Reset during beat 2 of a 4-beat read.
    ack_dly_max = 3;
    send_cmd(0, 16'($urandom), 32'h0, 3'd3);
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk); #2;
      if (exp_bus.size() == 2 && bus_req) seen = 1;
    end
    if (!seen) fail("beat2_not_reached");
    rst_n = 0;
    #1;
    check("rst_mid_req", 64'(bus_req), 64'(0));
    check("rst_mid_count", 64'(count), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_mid_empty", 64'(empty), 64'(1));
    ack_dly_max = 0;
    send_cmd(1, 16'h0042, 32'hCAFEF00D, 3'd0);
    wait_done(0, lat);
    check("post_reset_write_latency", 64'(lat), 64'(3));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
